pdm_dual_xmit: RTL and testbench
================================

Name: pdm_dual_xmit

Overview:
Stereo PDM source that emulates a pair of PDM microphones sharing one data line, as the far end of the dual PDM receiver. It accepts signed PCM sample pairs over a valid/ready handshake and runs one first-order sigma-delta modulator per channel. It follows an externally supplied pdm_clk, driving the left bit during the pdm_clk high phase and the right bit during the low phase. It serves as an on-chip stimulus and loopback source for the PDM receive path.

Parameters:
WIDTH, 16, PCM sample width in bits (two's complement)
DECIM, 64, pdm_clk periods per PCM sample pair (power of two, >= 2)
SYNC_STAGES, 2, flops in the pdm_clk synchronizer (>= 2)

Ports:
clk  in  1  system clock; all logic is in this domain
rst  in  1  synchronous, active-high reset
enable  in  1  1 = drive the line; 0 = release the line and freeze the modulators
mode  in  1  1 = stereo (drive both phases); 0 = mono (drive left phase only)
pdm_clk  in  1  bit clock from the receiver; asynchronous to clk
sample_l  in  WIDTH  left PCM sample, signed
sample_r  in  WIDTH  right PCM sample, signed
sample_valid  in  1  sample pair is offered
sample_ready  out  1  holding buffer can accept a pair
pdm_data  out  1  serial PDM bit
pdm_oe  out  1  output enable for the pdm_data pad (tri-state control)
underrun  out  1  one-cycle pulse: a PCM period started with the holding buffer empty

Behaviour:
- Reset values: pdm_data=0, pdm_oe=0, sample_ready=1, underrun=0. Holding buffer is empty, active samples are 0, both accumulators are 0, period counter is 0, and the synchronizer is cleared.
- Synchronizer: pdm_clk passes through SYNC_STAGES flops, plus one history flop for edge detection. rise = synced & ~hist; fall = ~synced & hist. Each is a one-cycle strobe.
- Output timing: pdm_data and pdm_oe update on the clk edge after the rise/fall strobe. Latency from a pdm_clk edge to output is SYNC_STAGES+1 clk cycles.
- Handshake: a transfer occurs when sample_valid && sample_ready. The pair is captured into a one-deep holding buffer. sample_ready = !holding_full and is registered; it has no combinational path from any input.
- PCM period: a period counter (log2 DECIM bits) advances on each rise while enable=1. At a rise with the counter at 0, the load step runs:
  - Holding buffer full: move it into the active left/right registers and mark it empty.
  - Holding buffer empty: keep the previous active samples and pulse underrun.
- Simultaneous load and transfer in the same cycle: the load takes the old holding contents, and the new pair lands in the holding buffer, which stays full. No pair is lost or duplicated.
- Modulator, per channel:
  - u = sample with its MSB inverted (offset binary, unsigned WIDTH bits).
  - s = acc + u, computed WIDTH+1 bits wide.
  - Output bit = s[WIDTH]; acc <= s[WIDTH-1:0].
  - Ones density equals u / 2^WIDTH. Wrap-around is by carry only; no saturation is needed.
  - On a load rise, the newly loaded sample is used for that same bit.
- Left channel: on rise with enable=1, step the left modulator, set pdm_data = left bit and pdm_oe = 1.
- Right channel, on fall with enable=1:
  - mode=1: step the right modulator, set pdm_data = right bit and pdm_oe = 1.
  - mode=0: pdm_oe = 0, pdm_data = 0, and the right accumulator holds.
- Disabled (enable=0): pdm_oe = 0 and pdm_data = 0 on the next clk. Accumulators and the period counter hold. The handshake still operates, and no underrun is flagged.
- Re-enable: the first action is at the next rise. A fall seen before any rise after enable does not drive the line.
- Mode change takes effect at the next fall.
- Reset mid-operation: all state returns to reset values on the next clk, regardless of pdm_clk. Any pair in the holding buffer is discarded.
- pdm_clk stopped: the outputs hold their last values and no underrun is flagged.

Test Plan:
- Reset, DECIM=64, mode=1, enable=1, L=R=0x0000 loaded before the first rise -> each channel emits 0,1,0,1,…; 32 ones per channel over 64 periods; underrun never asserted.
- L=0x7FFF, R=0x8000 -> left emits 0 then all 1s (63 ones in the first 64 bits); right emits all 0s; pdm_oe=1 in both phases.
- pdm_clk period = 20 clk cycles -> pdm_data and pdm_oe change exactly SYNC_STAGES+1=3 clk cycles after each pdm_clk edge; left value is stable through the high phase and right value through the low phase.
- No sample_valid after the first pair -> underrun pulses once at each period boundary (every 64 rises); output pattern continues with the last pair; sample_ready stays 1.
- sample_valid held high with a new pair each time ready is high, including a transfer in the same cycle as a load -> the pairs are consumed in order, one per 64 rises; no drop, no duplicate (check with an incrementing sample sequence).
- mode=0 -> pdm_oe=0 throughout every low phase; enable deasserted mid-period -> pdm_oe=0 within 1 clk; rst asserted mid-stream -> all outputs return to reset values on the next clk, and the first bit after re-enable is the left bit at the next rise.

Source files
------------

// File: rtl/pdm_dual_xmit.sv
// Stereo PDM source: emulates two PDM microphones sharing one data line.
// PCM pairs arrive over valid/ready into a one-deep holding buffer, are
// loaded into the active registers once per PCM period, and each channel
// runs a first-order sigma-delta modulator. The left bit is driven during
// the pdm_clk high phase and the right bit during the low phase.
module pdm_dual_xmit #(
    parameter int WIDTH       = 16,
    parameter int DECIM       = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic             pdm_clk,
    input  logic [WIDTH-1:0] sample_l,
    input  logic [WIDTH-1:0] sample_r,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pdm_data,
    output logic             pdm_oe,
    output logic             underrun
);

    localparam int CW = $clog2(DECIM);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // One modulator step: offset-binary sample added to the accumulator,
    // carry out is the PDM bit, low WIDTH bits are the new accumulator.
    function automatic logic [WIDTH:0] mod_step(
        input logic [WIDTH-1:0] acc,
        input logic [WIDTH-1:0] smp
    );
        logic [WIDTH-1:0] u;
        u = {~smp[WIDTH-1], smp[WIDTH-2:0]};
        return {1'b0, acc} + {1'b0, u};
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;
    logic                   rise_s;
    logic                   fall_s;

    logic                   hold_full_r;
    logic [WIDTH-1:0]       hold_l_r;
    logic [WIDTH-1:0]       hold_r_r;
    logic                   sample_ready_r;

    logic [WIDTH-1:0]       act_l_r;
    logic [WIDTH-1:0]       act_r_r;
    logic [WIDTH-1:0]       acc_l_r;
    logic [WIDTH-1:0]       acc_r_r;
    logic [CW-1:0]          cnt_r;
    logic                   armed_r;

    logic                   pdm_data_r;
    logic                   pdm_oe_r;
    logic                   underrun_r;

    logic                   load_s;
    logic                   take_s;
    logic                   xfer_s;
    logic                   hold_full_nxt_s;
    logic [WIDTH-1:0]       cur_l_s;
    logic [WIDTH-1:0]       cur_r_s;
    logic [WIDTH:0]         sum_l_s;
    logic [WIDTH:0]         sum_r_s;

    // Synchronize pdm_clk into clk and keep one history flop for edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pdm_clk};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_s = sync_r[SYNC_STAGES-1] & ~hist_r;
    assign fall_s = ~sync_r[SYNC_STAGES-1] & hist_r;

    // A load step takes the holding buffer only if it is full; a pair
    // arriving in the same cycle refills it, so nothing is lost.
    assign load_s          = rise_s & enable & (cnt_r == CNT_ZERO);
    assign take_s          = load_s & hold_full_r;
    assign xfer_s          = sample_valid & sample_ready_r;
    assign hold_full_nxt_s = (hold_full_r & ~take_s) | xfer_s;
    assign cur_l_s         = take_s ? hold_l_r : act_l_r;
    assign cur_r_s         = take_s ? hold_r_r : act_r_r;
    assign sum_l_s         = mod_step(acc_l_r, cur_l_s);
    assign sum_r_s         = mod_step(acc_r_r, act_r_r);

    // Holding buffer and registered ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_r    <= 1'b0;
            hold_l_r       <= {WIDTH{1'b0}};
            hold_r_r       <= {WIDTH{1'b0}};
            sample_ready_r <= 1'b1;
        end else begin
            hold_full_r    <= hold_full_nxt_s;
            sample_ready_r <= ~hold_full_nxt_s;
            if (xfer_s) begin
                hold_l_r <= sample_l;
                hold_r_r <= sample_r;
            end
        end
    end

    // Period counter, sample load, modulators and the registered line drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_l_r    <= {WIDTH{1'b0}};
            act_r_r    <= {WIDTH{1'b0}};
            acc_l_r    <= {WIDTH{1'b0}};
            acc_r_r    <= {WIDTH{1'b0}};
            cnt_r      <= CNT_ZERO;
            armed_r    <= 1'b0;
            pdm_data_r <= 1'b0;
            pdm_oe_r   <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= 1'b0;
            if (!enable) begin
                // Release the line; modulators and counter freeze, and the
                // next fall is ignored until a rise re-arms the right phase.
                pdm_data_r <= 1'b0;
                pdm_oe_r   <= 1'b0;
                armed_r    <= 1'b0;
            end else if (rise_s) begin
                cnt_r <= cnt_r + CNT_ONE;
                if (load_s) begin
                    act_l_r    <= cur_l_s;
                    act_r_r    <= cur_r_s;
                    underrun_r <= ~hold_full_r;
                end
                acc_l_r    <= sum_l_s[WIDTH-1:0];
                pdm_data_r <= sum_l_s[WIDTH];
                pdm_oe_r   <= 1'b1;
                armed_r    <= 1'b1;
            end else if (fall_s && armed_r) begin
                if (mode) begin
                    acc_r_r    <= sum_r_s[WIDTH-1:0];
                    pdm_data_r <= sum_r_s[WIDTH];
                    pdm_oe_r   <= 1'b1;
                end else begin
                    pdm_data_r <= 1'b0;
                    pdm_oe_r   <= 1'b0;
                end
            end
        end
    end

    assign sample_ready = sample_ready_r;
    assign pdm_data     = pdm_data_r;
    assign pdm_oe       = pdm_oe_r;
    assign underrun     = underrun_r;

endmodule

// File: tb/tb_pdm_dual_xmit.sv
// Self-checking bench for pdm_dual_xmit: randomized PCM pairs, a behavioural
// model (signed sample + half-scale, carry of a running sum) and a FIFO of
// transferred pairs indexed by load order.
module tb_pdm_dual_xmit;

    localparam int W    = 16;
    localparam int D    = 64;
    localparam int SS   = 2;
    localparam int HALF = 10;
    localparam int FULL = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         mode = 1'b1;
    logic         pdm_clk = 1'b0;
    logic [W-1:0] sample_l = '0;
    logic [W-1:0] sample_r = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic         pdm_data;
    logic         pdm_oe;
    logic         underrun;

    always #5 clk = ~clk;

    pdm_dual_xmit #(.WIDTH(W), .DECIM(D), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .pdm_clk(pdm_clk),
        .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .pdm_data(pdm_data), .pdm_oe(pdm_oe),
        .underrun(underrun)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [2*W-1:0] tx_q[$];
    int sent_idx = 0;
    int mdl_rd = 0;
    int und_cnt = 0;

    int m_cnt = 0, m_acc_l = 0, m_acc_r = 0, m_exp_under = 0;
    logic [W-1:0] m_act_l = '0, m_act_r = '0;
    logic m_armed = 1'b0, m_data = 1'b0, m_oe = 1'b0;
    int ones_l = 0, ones_r = 0;

    // Offer queued pairs in order.
    always @(negedge clk) begin
        if (sent_idx < tx_q.size()) begin
            sample_valid = 1'b1;
            {sample_l, sample_r} = tx_q[sent_idx];
        end else begin
            sample_valid = 1'b0;
        end
    end

    // Record handshakes as they happen.
    always @(posedge clk) begin
        if (!rst && sample_valid === 1'b1 && sample_ready === 1'b1) sent_idx++;
    end

    // Count underrun pulses.
    always @(negedge clk) begin
        if (underrun === 1'b1) und_cnt++;
    end

    // One modulator step: density = (signed value + half scale) / 2^W.
    task automatic mstep(input int acc_in, input logic [W-1:0] smp,
                         output int acc_out, output logic b);
        int u, s;
        u = int'($signed(smp)) + (FULL / 2);
        s = acc_in + u;
        b = (s >= FULL);
        acc_out = b ? s - FULL : s;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_acc_l = 0; m_acc_r = 0;
        m_act_l = '0; m_act_r = '0;
        m_armed = 1'b0; m_data = 1'b0; m_oe = 1'b0;
        mdl_rd = sent_idx;
    endtask

    task automatic pdm_rise(input bit push_at_load, input logic [2*W-1:0] pair);
        logic b;
        @(negedge clk); pdm_clk = 1'b1;
        @(negedge clk);
        if (push_at_load) begin #1; tx_q.push_back(pair); end
        @(negedge clk);
        if (pdm_data !== m_data || pdm_oe !== m_oe) begin
            $display("FAIL rise_early: data/oe %b%b expected %b%b", pdm_data, pdm_oe, m_data, m_oe);
        end else n_pass++;
        n_total++;
        if (enable) begin
            if (m_cnt == 0) begin
                if (sent_idx > mdl_rd) begin
                    {m_act_l, m_act_r} = tx_q[mdl_rd];
                    mdl_rd++;
                end else m_exp_under++;
            end
            m_cnt = (m_cnt + 1) % D;
            mstep(m_acc_l, m_act_l, m_acc_l, b);
            m_data = b; m_oe = 1'b1; m_armed = 1'b1;
        end else begin
            m_data = 1'b0; m_oe = 1'b0; m_armed = 1'b0;
        end
        @(negedge clk);
        if (pdm_data !== m_data || pdm_oe !== m_oe || sample_ready !== (sent_idx == mdl_rd)) begin
            $display("FAIL rise_edge: data/oe/ready %b%b%b expected %b%b%b", pdm_data, pdm_oe,
                     sample_ready, m_data, m_oe, (sent_idx == mdl_rd));
        end else n_pass++;
        n_total++;
        if (pdm_oe === 1'b1 && pdm_data === 1'b1) ones_l++;
        repeat (HALF - 4) @(negedge clk);
        if (pdm_data !== m_data || pdm_oe !== m_oe) begin
            $display("FAIL rise_hold: data/oe %b%b expected %b%b", pdm_data, pdm_oe, m_data, m_oe);
        end else n_pass++;
        n_total++;
    endtask

    task automatic pdm_fall();
        logic b;
        @(negedge clk); pdm_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (pdm_data !== m_data || pdm_oe !== m_oe) begin
            $display("FAIL fall_early: data/oe %b%b expected %b%b", pdm_data, pdm_oe, m_data, m_oe);
        end else n_pass++;
        n_total++;
        if (!enable) begin
            m_data = 1'b0; m_oe = 1'b0; m_armed = 1'b0;
        end else if (m_armed) begin
            if (mode) begin
                mstep(m_acc_r, m_act_r, m_acc_r, b);
                m_data = b; m_oe = 1'b1;
            end else begin
                m_data = 1'b0; m_oe = 1'b0;
            end
        end
        @(negedge clk);
        if (pdm_data !== m_data || pdm_oe !== m_oe || sample_ready !== (sent_idx == mdl_rd)) begin
            $display("FAIL fall_edge: data/oe/ready %b%b%b expected %b%b%b", pdm_data, pdm_oe,
                     sample_ready, m_data, m_oe, (sent_idx == mdl_rd));
        end else n_pass++;
        n_total++;
        if (pdm_oe === 1'b1 && pdm_data === 1'b1) ones_r++;
        repeat (HALF - 4) @(negedge clk);
        if (pdm_data !== m_data || pdm_oe !== m_oe) begin
            $display("FAIL fall_hold: data/oe %b%b expected %b%b", pdm_data, pdm_oe, m_data, m_oe);
        end else n_pass++;
        n_total++;
    endtask

    task automatic run_periods(input int n);
        for (int i = 0; i < n; i++) begin
            pdm_rise(1'b0, '0);
            pdm_fall();
        end
    endtask

    task automatic wait_sent();
        for (int i = 0; i < 200 && sent_idx < tx_q.size(); i++) @(negedge clk);
        if (sent_idx != tx_q.size()) begin
            $display("FAIL handshake_timeout: sent %0d expected %0d", sent_idx, tx_q.size());
        end else n_pass++;
        n_total++;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        if (pdm_data !== 1'b0 || pdm_oe !== 1'b0 || sample_ready !== 1'b1 || underrun !== 1'b0) begin
            $display("FAIL reset_values: data/oe/ready/underrun %b%b%b%b expected 0010",
                     pdm_data, pdm_oe, sample_ready, underrun);
        end else n_pass++;
        n_total++;
        model_reset();
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        apply_reset();
    endtask

    task automatic test_zero_pair();
        tx_q.push_back({W'(0), W'(0)});
        wait_sent();
        enable = 1'b1; mode = 1'b1;
        ones_l = 0; ones_r = 0;
        run_periods(D);
        if (ones_l != 32 || ones_r != 32) begin
            $display("FAIL zero_density: ones l/r %0d/%0d expected 32/32", ones_l, ones_r);
        end else n_pass++;
        n_total++;
        if (und_cnt != m_exp_under) begin
            $display("FAIL zero_underrun: count %0d expected %0d", und_cnt, m_exp_under);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_extremes();
        tx_q.push_back({W'(16'h7FFF), W'(16'h8000)});
        wait_sent();
        ones_l = 0; ones_r = 0;
        run_periods(D);
        if (ones_l != 63 || ones_r != 0) begin
            $display("FAIL extreme_density: ones l/r %0d/%0d expected 63/0", ones_l, ones_r);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_underrun();
        logic sd, so;
        int uc;
        tx_q.push_back({W'($urandom), W'($urandom)});
        wait_sent();
        run_periods(2 * D + 1);
        repeat (2) @(negedge clk);
        if (und_cnt != m_exp_under) begin
            $display("FAIL underrun_count: count %0d expected %0d", und_cnt, m_exp_under);
        end else n_pass++;
        n_total++;
        sd = m_data; so = m_oe; uc = m_exp_under;
        repeat (60) @(negedge clk);
        if (pdm_data !== sd || pdm_oe !== so || und_cnt != uc) begin
            $display("FAIL clk_stopped: data/oe/und %b%b%0d expected %b%b%0d",
                     pdm_data, pdm_oe, und_cnt, sd, so, uc);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] base;
        for (int i = 0; i < D && m_cnt != 0; i++) begin
            pdm_rise(1'b0, '0);
            pdm_fall();
        end
        base = W'($urandom);
        pdm_rise(1'b1, {base, ~base});
        pdm_fall();
        for (int k = 1; k < 4; k++) tx_q.push_back({W'(base + W'(k)), W'(~(base + W'(k)))});
        run_periods(4 * D);
        repeat (2) @(negedge clk);
        if (und_cnt != m_exp_under) begin
            $display("FAIL b2b_underrun: count %0d expected %0d", und_cnt, m_exp_under);
        end else n_pass++;
        n_total++;
        if (sent_idx != tx_q.size()) begin
            $display("FAIL b2b_consumed: sent %0d expected %0d", sent_idx, tx_q.size());
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_mode_disable();
        mode = 1'b0;
        run_periods(8);
        mode = 1'b1;
        run_periods(4);
        pdm_rise(1'b0, '0);
        enable = 1'b0;
        @(negedge clk);
        if (pdm_data !== 1'b0 || pdm_oe !== 1'b0) begin
            $display("FAIL disable_1clk: data/oe %b%b expected 00", pdm_data, pdm_oe);
        end else n_pass++;
        n_total++;
        m_data = 1'b0; m_oe = 1'b0; m_armed = 1'b0;
        pdm_fall();
        pdm_rise(1'b0, '0);
        enable = 1'b1;
        pdm_fall();
        run_periods(4);
    endtask

    task automatic test_reset_mid();
        tx_q.push_back({W'($urandom), W'($urandom)});
        wait_sent();
        pdm_rise(1'b0, '0);
        pdm_fall();
        apply_reset();
        tx_q.push_back({W'($urandom), W'($urandom)});
        wait_sent();
        run_periods(6);
        repeat (2) @(negedge clk);
        if (und_cnt != m_exp_under) begin
            $display("FAIL reset_underrun: count %0d expected %0d", und_cnt, m_exp_under);
        end else n_pass++;
        n_total++;
    endtask

    initial begin
        test_reset();
        test_zero_pair();
        test_extremes();
        test_underrun();
        test_back_to_back();
        test_mode_disable();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
